// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit.
// Access size encoding, FSM states and the registered request bundle.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } state_e;

  typedef struct packed {
    logic        write;
    size_e       size;
    logic        uns;
    logic [31:0] wdata;
  } lsu_req_t;

  // Illegal size, or an access not naturally aligned to its size.
  function automatic logic bad_access(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    logic bad;
    bad = 1'b0;
    unique case (1'b1)
      size == SZ_BAD:  bad = 1'b1;
      size == SZ_HALF: bad = lo[0];
      size == SZ_WORD: bad = |lo;
      default:         bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane steering for the load/store unit.
// Extracts and extends load data; merges sub-word store data into a word.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lo,
  input  size_e       size,
  input  logic        uns,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  b;
  logic [15:0] h;
  logic [4:0]  sh;

  always_comb begin
    sh        = {lo, 3'b000};
    b         = word[sh +: 8];
    h         = lo[1] ? word[31:16] : word[15:0];
    load_data = word;
    merged    = wdata;
    unique case (1'b1)
      size == SZ_BYTE: begin
        load_data = {{24{b[7] & ~uns}}, b};
        merged    = word;
        merged[sh +: 8] = wdata[7:0];
      end
      size == SZ_HALF: begin
        load_data = {{16{h[15] & ~uns}}, h};
        merged    = lo[1] ? {wdata[15:0], word[15:0]}
                          : {word[31:16], wdata[15:0]};
      end
      default: begin
        load_data = word;
        merged    = wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit bridging a CPU request channel to a word memory.
// Sub-word stores are read-modify-write; misaligned requests error out.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_error,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  output logic              mem_write_enable,
  input  logic [31:0]       mem_read_data
);

  state_e            state;
  lsu_req_t          rq;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wword_q;
  logic [31:0]       lane_load;
  logic [31:0]       lane_merge;
  logic              accept;
  logic              bad;
  logic              mem_act;

  assign req_ready  = state == IDLE;
  assign resp_valid = state == RESP;
  assign accept     = req_valid && req_ready;
  assign bad        = bad_access(req_size, req_addr[1:0]);

  assign mem_act          = (state == READ) || (state == WRITE);
  assign mem_write_enable = state == WRITE;
  assign mem_address      = mem_act ? (addr_q >> 2) : '0;
  assign mem_write_data   = mem_write_enable ? wword_q : '0;

  lsu_byte_lane u_lane (
    .word      (mem_read_data),
    .lo        (addr_q[1:0]),
    .size      (rq.size),
    .uns       (rq.uns),
    .wdata     (rq.wdata),
    .load_data (lane_load),
    .merged    (lane_merge)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rq         <= '0;
      addr_q     <= '0;
      wword_q    <= '0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            rq.write   <= req_write;
            rq.size    <= size_e'(req_size);
            rq.uns     <= req_unsigned;
            rq.wdata   <= req_wdata;
            addr_q     <= req_addr;
            wword_q    <= req_wdata;
            resp_rdata <= '0;
            resp_error <= bad;
            if (bad)
              state <= RESP;
            else if (req_write && req_size == SZ_WORD)
              state <= WRITE;
            else
              state <= READ;
          end
        end
        READ: begin
          if (rq.write) begin
            wword_q <= lane_merge;
            state   <= WRITE;
          end else begin
            resp_rdata <= lane_load;
            state      <= RESP;
          end
        end
        WRITE: state <= RESP;
        RESP: begin
          if (resp_ready) begin
            resp_rdata <= '0;
            resp_error <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
